// File: rtl/dmem_responder_pkg.sv
// Shared types for the dmem responder: FSM states, latched request kinds and timer width.
package dmem_responder_types;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    op_read,
    op_write,
    op_illegal
  } op_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with byte-lane write mask and registered read data.
module dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Read data register only updates on a read access, so it holds between accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the RV32I dmem port: one request at a time, fixed latency, one-cycle resp.
//   state | meaning
//   IDLE  | waiting for dmem_read/dmem_write; accepts on the next edge
//   WAIT  | latency countdown on the latched request, inputs ignored
//   RESP  | access performed on entry edge; dmem_resp high for this cycle
module dmem_responder
  import dmem_responder_types::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_address,
  input  logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_error,
  output logic        busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "dmem_responder: LATENCY must be in 1..15");
  end

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;

  op_t                   op_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  oor_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic                  rd_zero_q;

  op_t                   op_in;
  logic                  oor_in;
  logic                  req_in;
  logic                  addr_unused;

  op_t                   acc_op;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_oor;
  logic [3:0]            acc_be;
  logic [31:0]           acc_wdata;
  logic                  enter_resp;
  logic                  arr_en;
  logic                  arr_we;
  logic [31:0]           arr_rdata;

  assign req_in      = dmem_read | dmem_write;
  assign oor_in      = |dmem_address[31:DEPTH_LOG2+2];
  assign addr_unused = ^dmem_address[1:0];

  always_comb begin
    op_in = op_read;
    if (dmem_read && dmem_write) op_in = op_illegal;
    else if (dmem_write)         op_in = op_write;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_in) begin
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the access happens on the accept edge itself, before the latches load.
  always_comb begin
    acc_op    = op_q;
    acc_idx   = idx_q;
    acc_oor   = oor_q;
    acc_be    = be_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_op    = op_in;
      acc_idx   = dmem_address[DEPTH_LOG2+1:2];
      acc_oor   = oor_in;
      acc_be    = dmem_byte_enable;
      acc_wdata = dmem_wdata;
    end
  end

  assign enter_resp = (state != RESP) && (state_nxt == RESP);
  assign arr_en     = enter_resp && (acc_op != op_illegal) && !acc_oor;
  assign arr_we     = (acc_op == op_write);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= op_read;
      idx_q     <= '0;
      oor_q     <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_in) begin
        op_q    <= op_in;
        idx_q   <= dmem_address[DEPTH_LOG2+1:2];
        oor_q   <= oor_in;
        be_q    <= dmem_byte_enable;
        wdata_q <= dmem_wdata;
      end
      if (enter_resp) begin
        err_q     <= acc_oor || (acc_op == op_illegal);
        rd_zero_q <= acc_oor || (acc_op != op_read);
      end
    end
  end

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .be    (acc_be),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // Array read register holds across accesses; the zero flag masks writes, errors and reset.
  assign dmem_rdata = rd_zero_q ? 32'h0 : arr_rdata;
  assign dmem_resp  = (state == RESP);
  assign dmem_error = (state == RESP) && err_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboarded accesses at LATENCY=2, reset abort, latency sweep.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        resp, err, busy;

  logic        rd2;
  logic [31:0] rdata_a, rdata_b;
  logic        resp_a, err_a, busy_a;
  logic        resp_b, err_b, busy_b;

  int total = 0;
  int bad   = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .dmem_read(rd), .dmem_write(wr), .dmem_address(addr),
    .dmem_byte_enable(be), .dmem_wdata(wdata), .dmem_rdata(rdata),
    .dmem_resp(resp), .dmem_error(err), .busy(busy)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .dmem_read(rd2), .dmem_write(1'b0), .dmem_address(32'h0),
    .dmem_byte_enable(4'h0), .dmem_wdata(32'h0), .dmem_rdata(rdata_a),
    .dmem_resp(resp_a), .dmem_error(err_a), .busy(busy_a)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst), .dmem_read(rd2), .dmem_write(1'b0), .dmem_address(32'h0),
    .dmem_byte_enable(4'h0), .dmem_wdata(32'h0), .dmem_rdata(rdata_b),
    .dmem_resp(resp_b), .dmem_error(err_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input string tag, input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] be_i, input logic [31:0] wd,
                     input logic exp_err, input logic [31:0] exp_rd);
    logic [32:0] got;
    int n;
    sb_q.push_back({exp_err, exp_rd});
    @(negedge clk);
    rd = r; wr = w; addr = a; be = be_i; wdata = wd;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp !== 1'b1 && n < 40);
    chk({tag, "_resp"}, 32'(resp), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'd2);
    got = (sb_q.size() > 0) ? sb_q.pop_front() : 33'h1_dead_dead;
    chk({tag, "_rdata"}, rdata, got[31:0]);
    chk({tag, "_err"}, 32'(err), 32'(got[32]));
    @(negedge clk);
    chk({tag, "_resp_width"}, 32'(resp), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_err_idle"}, 32'(err), 32'd0);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic sweep_check(input string tag, input int lat, input int rise0, input int rise1,
                             input int nrise, input int blen, input int roff, input int rcnt);
    chk({tag, "_accepts"}, 32'(nrise >= 2), 32'd1);
    chk({tag, "_spacing"}, 32'(rise1 - rise0), 32'(lat + 1));
    chk({tag, "_busy_len"}, 32'(blen), 32'(lat));
    chk({tag, "_resp_lat"}, 32'(roff), 32'(lat));
    chk({tag, "_resp_count"}, 32'(rcnt), 32'd1);
  endtask

  initial begin
    int hits;
    int ra[$], rb[$];
    int blen_a, blen_b, roff_a, roff_b, rcnt_a, rcnt_b;
    logic pb_a, pb_b;

    rd = 0; wr = 0; addr = 0; be = 0; wdata = 0; rd2 = 0;
    #12;
    chk("reset_resp", 32'(resp), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    req("wr_10",      0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0);
    req("rd_10",      1, 0, 32'h10, 4'h0, 32'h0,        0, 32'hDEADBEEF);
    req("sb_12",      0, 1, 32'h12, 4'h2, 32'h0000AA00, 0, 32'h0);
    req("rd_10_b",    1, 0, 32'h10, 4'h0, 32'h0,        0, 32'hDEADAAEF);
    req("rd_13",      1, 0, 32'h13, 4'h0, 32'h0,        0, 32'hDEADAAEF);
    req("wr_0",       0, 1, 32'h0,  4'hF, 32'h0BADF00D, 0, 32'h0);
    req("rd_oor",     1, 0, 32'h1000, 4'h0, 32'h0,      1, 32'h0);
    req("rd_0",       1, 0, 32'h0,  4'h0, 32'h0,        0, 32'h0BADF00D);
    req("wr_20",      0, 1, 32'h20, 4'hF, 32'h12345678, 0, 32'h0);
    req("illegal_20", 1, 1, 32'h20, 4'hF, 32'hFFFFFFFF, 1, 32'h0);
    req("rd_20",      1, 0, 32'h20, 4'h0, 32'h0,        0, 32'h12345678);
    req("wr_be0",     0, 1, 32'h20, 4'h0, 32'hA5A5A5A5, 0, 32'h0);
    req("wr_oor",     0, 1, 32'h1000_0020, 4'hF, 32'h0, 1, 32'h0);
    req("rd_20_b",    1, 0, 32'h20, 4'h0, 32'h0,        0, 32'h12345678);
    req("wr_30",      0, 1, 32'h30, 4'hF, 32'h11111111, 0, 32'h0);

    // Abort a write in WAIT with an asynchronous reset.
    @(negedge clk);
    wr = 1'b1; addr = 32'h30; be = 4'hF; wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    wr  = 1'b0;
    #1;
    chk("abort_resp", 32'(resp), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp !== 1'b0) hits++;
    end
    chk("abort_no_resp", 32'(hits), 32'd0);
    rst = 1'b1;
    req("rd_30", 1, 0, 32'h30, 4'h0, 32'h0, 0, 32'h11111111);

    // Held read on the LATENCY=1 and LATENCY=15 instances.
    blen_a = 0; blen_b = 0; roff_a = 0; roff_b = 0; rcnt_a = 0; rcnt_b = 0;
    pb_a = 1'b0; pb_b = 1'b0;
    @(negedge clk);
    rd2 = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (busy_a && !pb_a) ra.push_back(i);
      if (busy_b && !pb_b) rb.push_back(i);
      if (ra.size() == 1) begin
        if (busy_a) blen_a++;
        if (resp_a === 1'b1) begin rcnt_a++; roff_a = i - ra[0] + 1; end
      end
      if (rb.size() == 1) begin
        if (busy_b) blen_b++;
        if (resp_b === 1'b1) begin rcnt_b++; roff_b = i - rb[0] + 1; end
      end
      pb_a = busy_a;
      pb_b = busy_b;
    end
    rd2 = 1'b0;
    sweep_check("lat1", 1, (ra.size() > 0) ? ra[0] : 0, (ra.size() > 1) ? ra[1] : -100,
                ra.size(), blen_a, roff_a, rcnt_a);
    sweep_check("lat15", 15, (rb.size() > 0) ? rb[0] : 0, (rb.size() > 1) ? rb[1] : -100,
                rb.size(), blen_b, roff_b, rcnt_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
